// File: rtl/st_framing_pkg.sv
// Shared types and helpers for the delimiter-framed Avalon-ST stages.
package st_framing_pkg;

    localparam int unsigned ST_DATA_W = 8;

    // One-hot framing state, same encoding style as the delimiter inserter
    typedef enum logic [2:0] {
        OUT_PKT  = 3'b001,
        PKT_OPEN = 3'b010,
        PKT_HELD = 3'b100
    } framer_state_e;

    // Output beat payload at the default data width
    typedef struct packed {
        logic [ST_DATA_W-1:0] data;
        logic                 sop;
        logic                 eop;
    } st_beat_t;

    // Increment that sticks at the all-ones value of a width-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] limit;
        limit = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/st_output_stage.sv
// One-entry registered Avalon-ST output register with ready/valid handling.
module st_output_stage
    import st_framing_pkg::*;
#(
    parameter type beat_t = st_beat_t
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  beat_t load_beat,
    input  logic  ready,
    output logic  valid,
    output beat_t beat,
    output logic  space_c
);

    // Register can take a new beat when empty or retiring this cycle
    assign space_c = ~valid | ready;

    // Load has priority over retire so back-to-back beats stream at full rate
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            beat  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            beat  <= load_beat;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/st_delimiter_framer.sv
// Strips SOP/EOP delimiter words and re-frames payload as Avalon-ST packets.
module st_delimiter_framer
    import st_framing_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [WIDTH-1:0]     pkt_tag,
    output logic [WIDTH-1:0]     pkt_trailer,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
    } beat_t;

    framer_state_e    state;
    framer_state_e    state_next;
    logic [WIDTH-1:0] hold_data;
    logic             hold_first;

    logic  space_c;
    logic  accept;
    logic  is_err;
    logic  is_sop;
    logic  is_eop;
    logic  is_pay;

    logic  emit;
    beat_t emit_beat;
    beat_t out_beat;
    logic  hold_load;
    logic  hold_first_new;
    logic  tag_load;
    logic  trailer_load;
    logic  pkt_inc;
    logic  drop_inc;
    logic  err_inc;

    // Every accept, emitting or not, waits for room in the output register
    assign in_ready = ~reset & space_c;
    assign accept   = in_valid & in_ready;

    // Beat classification; both flags together is a malformed delimiter
    assign is_err = in_sop & in_eop;
    assign is_sop = in_sop & ~in_eop;
    assign is_eop = in_eop & ~in_sop;
    assign is_pay = ~in_sop & ~in_eop;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OUT_PKT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; malformed beats never move the FSM
    always_comb begin
        state_next = state;
        if (accept && !is_err) begin
            case (state)
                OUT_PKT: begin
                    if (is_sop) state_next = PKT_OPEN;
                end
                PKT_OPEN: begin
                    if (is_pay)      state_next = PKT_HELD;
                    else if (is_eop) state_next = OUT_PKT;
                end
                PKT_HELD: begin
                    if (is_eop)      state_next = OUT_PKT;
                    else if (is_sop) state_next = PKT_OPEN;
                end
                default: state_next = OUT_PKT;
            endcase
        end
    end

    // Per-accept actions: emit held beat, reload hold, capture delimiters, bump counters
    always_comb begin
        emit           = 1'b0;
        emit_beat      = '0;
        hold_load      = 1'b0;
        hold_first_new = 1'b0;
        tag_load       = 1'b0;
        trailer_load   = 1'b0;
        pkt_inc        = 1'b0;
        drop_inc       = 1'b0;
        err_inc        = 1'b0;

        emit_beat.data = hold_data;
        emit_beat.sop  = hold_first;

        if (accept) begin
            if (is_err) begin
                err_inc = 1'b1;
            end else begin
                case (state)
                    OUT_PKT: begin
                        if (is_pay)      drop_inc = 1'b1;
                        else if (is_eop) err_inc  = 1'b1;
                        else             tag_load = 1'b1;
                    end
                    PKT_OPEN: begin
                        if (is_pay) begin
                            hold_load      = 1'b1;
                            hold_first_new = 1'b1;
                        end else if (is_eop) begin
                            trailer_load = 1'b1;
                        end else begin
                            err_inc  = 1'b1;
                            tag_load = 1'b1;
                        end
                    end
                    PKT_HELD: begin
                        emit = 1'b1;
                        if (is_pay) begin
                            hold_load = 1'b1;
                        end else if (is_eop) begin
                            emit_beat.eop = 1'b1;
                            trailer_load  = 1'b1;
                            pkt_inc       = 1'b1;
                        end else begin
                            // A new SOP implicitly closes the open packet
                            emit_beat.eop = 1'b1;
                            pkt_inc       = 1'b1;
                            err_inc       = 1'b1;
                            tag_load      = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lookahead hold, captured delimiters and saturating status counters
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_data   <= '0;
            hold_first  <= 1'b0;
            pkt_tag     <= '0;
            pkt_trailer <= '0;
            pkt_count   <= '0;
            drop_count  <= '0;
            err_count   <= '0;
        end else begin
            if (hold_load) begin
                hold_data  <= in_data;
                hold_first <= hold_first_new;
            end
            if (tag_load)     pkt_tag     <= in_data;
            if (trailer_load) pkt_trailer <= in_data;
            if (pkt_inc)  pkt_count  <= CNT_WIDTH'(sat_inc(32'(pkt_count), CNT_WIDTH));
            if (drop_inc) drop_count <= CNT_WIDTH'(sat_inc(32'(drop_count), CNT_WIDTH));
            if (err_inc)  err_count  <= CNT_WIDTH'(sat_inc(32'(err_count), CNT_WIDTH));
        end
    end

    st_output_stage #(
        .beat_t (beat_t)
    ) u_out (
        .clock     (clock),
        .reset     (reset),
        .load      (emit),
        .load_beat (emit_beat),
        .ready     (out_ready),
        .valid     (out_valid),
        .beat      (out_beat),
        .space_c   (space_c)
    );

    assign out_data = out_beat.data;
    assign out_sop  = out_beat.sop;
    assign out_eop  = out_beat.eop;

endmodule

// File: tb/tb_st_delimiter_framer.sv
// Directed bench for st_delimiter_framer with a retire-side beat monitor.
module tb_st_delimiter_framer;

    logic        clock;
    logic        reset;
    logic        in_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  pkt_tag;
    logic [7:0]  pkt_trailer;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    int         valid_seen = 0;
    int         got_base;
    int         valid_base;

    st_delimiter_framer #(
        .WIDTH     (8),
        .CNT_WIDTH (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_ready    (in_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .pkt_tag     (pkt_tag),
        .pkt_trailer (pkt_trailer),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count),
        .err_count   (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every beat that retires at the following rising edge
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            valid_seen++;
            if (out_ready) got.push_back({out_data, out_sop, out_eop});
        end
    end

    function automatic logic [9:0] bt(input logic [7:0] d, input logic s, input logic e);
        return {d, s, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one beat (called just after a rising edge) and hold it until accepted
    task automatic send(input logic s, input logic e, input logic [7:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic drain();
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        got_base   = got.size();
        valid_base = valid_seen;
        exp_q.delete();
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, 32'(got.size() - got_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (got_base + i) < got.size(); i++)
            chk({tag, "_beat"}, 32'(got[got_base + i]), 32'(exp_q[i]));
    endtask

    task automatic check_status(input string tag, input logic [7:0] tg, input logic [7:0] tr,
                                input logic [15:0] pc, input logic [15:0] dc, input logic [15:0] ec);
        chk({tag, "_tag"},     32'(pkt_tag),     32'(tg));
        chk({tag, "_trailer"}, 32'(pkt_trailer), 32'(tr));
        chk({tag, "_pkt"},     32'(pkt_count),   32'(pc));
        chk({tag, "_drop"},    32'(drop_count),  32'(dc));
        chk({tag, "_err"},     32'(err_count),   32'(ec));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        got_base  = 0;
        valid_base = 0;

        // Reset state
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_status("rst", 8'h00, 8'h00, 16'd0, 16'd0, 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // Basic three-beat packet plus lookahead latency
        do_reset();
        send(1'b1, 1'b0, 8'hA5);
        send(1'b0, 1'b0, 8'h01);
        chk("t1_held_no_valid", 32'(out_valid), 32'd0);
        send(1'b0, 1'b0, 8'h02);
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'({out_data, out_sop, out_eop}), 32'(bt(8'h01, 1'b1, 1'b0)));
        send(1'b0, 1'b0, 8'h03);
        send(1'b0, 1'b1, 8'h5A);
        drain();
        exp_q = '{bt(8'h01, 1'b1, 1'b0), bt(8'h02, 1'b0, 1'b0), bt(8'h03, 1'b0, 1'b1)};
        check_beats("t1");
        check_status("t1", 8'hA5, 8'h5A, 16'd1, 16'd0, 16'd0);

        // Single-payload packet
        do_reset();
        send(1'b1, 1'b0, 8'h11);
        send(1'b0, 1'b0, 8'h7E);
        send(1'b0, 1'b1, 8'h22);
        drain();
        exp_q = '{bt(8'h7E, 1'b1, 1'b1)};
        check_beats("t2");
        check_status("t2", 8'h11, 8'h22, 16'd1, 16'd0, 16'd0);

        // Empty packet emits nothing
        do_reset();
        send(1'b1, 1'b0, 8'h33);
        send(1'b0, 1'b1, 8'h44);
        drain();
        chk("t3_no_valid", 32'(valid_seen - valid_base), 32'd0);
        check_status("t3", 8'h33, 8'h44, 16'd0, 16'd0, 16'd0);

        // Eight beats with a five-cycle downstream stall
        do_reset();
        send(1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 8'(8'h80 + i));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h84;
        repeat (5) begin
            @(negedge clock);
            chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_data", 32'({out_data, out_sop, out_eop}), 32'(bt(8'h82, 1'b0, 1'b0)));
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(1'b0, 1'b0, 8'(8'h80 + i));
        send(1'b0, 1'b1, 8'h56);
        drain();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(bt(8'(8'h80 + i), i == 0, i == 7));
        check_beats("t4");
        check_status("t4", 8'h55, 8'h56, 16'd1, 16'd0, 16'd0);

        // Stray payload, then implicit close by a second SOP
        do_reset();
        send(1'b0, 1'b0, 8'h99);
        send(1'b1, 1'b0, 8'h01);
        send(1'b0, 1'b0, 8'h10);
        send(1'b1, 1'b0, 8'h02);
        send(1'b0, 1'b0, 8'h20);
        send(1'b0, 1'b1, 8'h03);
        drain();
        exp_q = '{bt(8'h10, 1'b1, 1'b1), bt(8'h20, 1'b1, 1'b1)};
        check_beats("t5");
        check_status("t5", 8'h02, 8'h03, 16'd2, 16'd1, 16'd1);

        // Malformed beat, stray EOP, double SOP in an open packet
        do_reset();
        send(1'b1, 1'b1, 8'hEE);
        send(1'b0, 1'b1, 8'h77);
        send(1'b0, 1'b0, 8'h12);
        check_status("t6a", 8'h00, 8'h00, 16'd0, 16'd1, 16'd2);
        send(1'b1, 1'b0, 8'h61);
        send(1'b1, 1'b0, 8'h62);
        send(1'b0, 1'b0, 8'h63);
        send(1'b0, 1'b1, 8'h64);
        drain();
        exp_q = '{bt(8'h63, 1'b1, 1'b1)};
        check_beats("t6");
        check_status("t6b", 8'h62, 8'h64, 16'd1, 16'd1, 16'd3);

        // Reset with a beat held and another in the output register
        do_reset();
        send(1'b1, 1'b0, 8'h40);
        send(1'b0, 1'b0, 8'h41);
        send(1'b0, 1'b0, 8'h42);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        chk("t7_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        chk("t7_out_valid", 32'(out_valid), 32'd0);
        chk("t7_out_data", 32'({out_data, out_sop, out_eop}), 32'd0);
        check_status("t7_rst", 8'h00, 8'h00, 16'd0, 16'd0, 16'd0);
        got_base   = got.size();
        valid_base = valid_seen;
        send(1'b1, 1'b0, 8'h70);
        send(1'b0, 1'b0, 8'h71);
        send(1'b0, 1'b0, 8'h72);
        send(1'b0, 1'b1, 8'h73);
        drain();
        exp_q = '{bt(8'h71, 1'b1, 1'b0), bt(8'h72, 1'b0, 1'b1)};
        check_beats("t7");
        check_status("t7", 8'h70, 8'h73, 16'd1, 16'd0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
